// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache line fills and D-cache fills or stores.
// Define ROUND_ROBIN_EN to alternate grants on contention; the default gives D priority.
module mem_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int WORDS_PER_LINE = 8,
    parameter int OFF_W          = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       fill_data,
    output logic [OFF_W-1:0]  fill_word,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              i_done,
    output logic              d_done,
    output logic              busy
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_I_FILL  = 3'd1;
    localparam logic [2:0] ST_D_FILL  = 3'd2;
    localparam logic [2:0] ST_D_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [OFF_W:0]    ISSUE_LAST = (OFF_W+1)'(WORDS_PER_LINE);
    localparam logic [OFF_W-1:0]  RET_LAST   = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK  = ADDR_W'(2 * WORDS_PER_LINE - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [OFF_W:0]    k_q, k_d;        // reads issued so far, saturates at W
    logic [OFF_W-1:0]  r_q, r_d;        // words returned so far
    logic              gnt_d_q, gnt_d_d; // 1 = D side owns the current transaction
`ifdef ROUND_ROBIN_EN
    logic              rr_q, rr_d;      // side granted last, 1 = D
`endif

    logic              pick_d;
    logic              in_fill;
    logic              ret;
    logic [ADDR_W-1:0] line_base;

`ifdef ROUND_ROBIN_EN
    assign pick_d = (d_req && i_req) ? ~rr_q : d_req;
`else
    assign pick_d = d_req;
`endif

    assign in_fill   = (state_q == ST_I_FILL) || (state_q == ST_D_FILL);
    assign ret       = in_fill && mem_valid;
    assign line_base = addr_q & ~LINE_MASK;

    // NOTE: every next-state variable takes its current value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        k_d     = k_q;
        r_d     = r_q;
        gnt_d_d = gnt_d_q;
`ifdef ROUND_ROBIN_EN
        rr_d    = rr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (d_req || i_req) begin
                    gnt_d_d = pick_d;
                    k_d     = '0;
                    r_d     = '0;
`ifdef ROUND_ROBIN_EN
                    rr_d    = pick_d;
`endif
                    if (pick_d) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        state_d = d_we ? ST_D_WRITE : ST_D_FILL;
                    end else begin
                        addr_d  = i_addr;
                        state_d = ST_I_FILL;
                    end
                end
            end
            ST_I_FILL, ST_D_FILL: begin
                if (k_q < ISSUE_LAST) begin
                    k_d = k_q + 1'b1;
                end
                // Requests are not looked at here: in-flight reads always drain.
                if (mem_valid) begin
                    r_d = r_q + 1'b1;
                    if (r_q == RET_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_D_WRITE: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            k_q     <= '0;
            r_q     <= '0;
            gnt_d_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
            rr_q    <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            k_q     <= k_d;
            r_q     <= r_d;
            gnt_d_q <= gnt_d_d;
`ifdef ROUND_ROBIN_EN
            rr_q    <= rr_d;
`endif
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (in_fill && (k_q < ISSUE_LAST)) begin
            mem_en   = 1'b1;
            mem_addr = line_base + ADDR_W'({k_q[OFF_W-1:0], 1'b0});
        end else if (state_q == ST_D_WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
    end

    // Returns outside a fill (idle, store, or after a reset) are dropped here.
    assign fill_data = ret ? mem_rdata : 16'h0000;
    assign fill_word = ret ? r_q : '0;
    assign i_fill_we = ret && !gnt_d_q;
    assign d_fill_we = ret && gnt_d_q;
    assign i_done    = (state_q == ST_DONE) && !gnt_d_q;
    assign d_done    = (state_q == ST_DONE) && gnt_d_q;
    assign busy      = (state_q != ST_IDLE);

`ifndef SYNTHESIS
    a_fill_excl: assert property (@(posedge clk) disable iff (!rst_n) !(i_fill_we && d_fill_we));
    a_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(i_done && d_done));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle fixed-latency memory model.
// Expectations follow the ROUND_ROBIN_EN setting used for the build.
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int W      = 8;
    localparam int OFF_W  = 3;
    localparam int LAT    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [15:0]       d_wdata = '0;
    logic              mem_en, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata, mem_rdata;
    logic              mem_valid;
    logic [15:0]       fill_data;
    logic [OFF_W-1:0]  fill_word;
    logic              i_fill_we, d_fill_we, i_done, d_done, busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .WORDS_PER_LINE(W), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .i_done(i_done), .d_done(d_done), .busy(busy)
    );

    // Memory: read data is address ^ 0xA5A5, returned LAT cycles after the read is issued.
    logic [LAT-1:0] vpipe = '0;
    logic [15:0]    apipe [LAT];
    always @(posedge clk) begin
        vpipe    <= {vpipe[LAT-2:0], mem_en & ~mem_wr};
        apipe[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign mem_valid = vpipe[LAT-1];
    assign mem_rdata = mem_valid ? (apipe[LAT-1] ^ 16'hA5A5) : 16'hDEAD;

    // Activity log, sampled on the falling edge.
    int          cyc = 0;
    logic [15:0] rd_addr [$];
    logic [15:0] wr_addr [$];
    logic [15:0] wr_data [$];
    int          wr_cyc  [$];
    logic [2:0]  fw      [$];
    logic [15:0] fd      [$];
    bit          fside   [$];
    int          i_done_cnt, d_done_cnt, d_done_cyc, both_err, valid_cnt;

    always @(negedge clk) begin
        cyc++;
        if (mem_en && !mem_wr) rd_addr.push_back(mem_addr);
        if (mem_en && mem_wr) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (i_fill_we || d_fill_we) begin
            fw.push_back(fill_word);
            fd.push_back(fill_data);
            fside.push_back(d_fill_we);
        end
        if ((i_fill_we && d_fill_we) || (i_done && d_done)) both_err++;
        if (i_done) i_done_cnt++;
        if (d_done) begin
            d_done_cnt++;
            d_done_cyc = cyc;
        end
        if (mem_valid) valid_cnt++;
    end

    task automatic clear_logs;
        @(posedge clk); #1;
        rd_addr.delete(); wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        fw.delete(); fd.delete(); fside.delete();
        i_done_cnt = 0; d_done_cnt = 0; d_done_cyc = -1; both_err = 0; valid_cnt = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        total++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata} !== 34'd0) $display("FAIL reset_mem: got %h want 0", {mem_en, mem_wr, mem_addr, mem_wdata});
        else passed++;
        total++;
        if ({fill_data, fill_word, i_fill_we, d_fill_we} !== 21'd0) $display("FAIL reset_fill: got %h want 0", {fill_data, fill_word, i_fill_we, d_fill_we});
        else passed++;
        total++;
        if ({i_done, d_done, busy} !== 3'b000) $display("FAIL reset_done_busy: got %b want 000", {i_done, d_done, busy});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_i_fill;
        int n = 0;
        clear_logs();
        i_req = 1'b1; i_addr = 16'h0036;
        do begin @(negedge clk); n++; end while (!i_done && n < 100);
        total++;
        if (!i_done) $display("FAIL ifill_timeout: i_done=%b after %0d cycles want 1", i_done, n);
        else passed++;
        i_req = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) $display("FAIL ifill_busy: got %b want 0", busy); else passed++;
        total++;
        if (rd_addr.size() != W) $display("FAIL ifill_nreads: got %0d want %0d", rd_addr.size(), W); else passed++;
        for (int k = 0; k < W; k++) begin
            logic [15:0] ea;
            ea = 16'h0030 + 16'(2 * k);
            total++;
            if (rd_addr[k] !== ea || fw[k] !== 3'(k) || fd[k] !== (ea ^ 16'hA5A5) || fside[k] !== 1'b0)
                $display("FAIL ifill_word%0d: addr %h word %0d data %h side %b want %h %0d %h 0", k, rd_addr[k], fw[k], fd[k], fside[k], ea, k, ea ^ 16'hA5A5);
            else passed++;
        end
        total++;
        if (fw.size() != W || i_done_cnt != 1 || d_done_cnt != 0 || both_err != 0)
            $display("FAIL ifill_counts: fills %0d idone %0d ddone %0d excl %0d want %0d 1 0 0", fw.size(), i_done_cnt, d_done_cnt, both_err, W);
        else passed++;
    endtask

    task automatic test_d_write;
        int n = 0;
        clear_logs();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h1000; d_wdata = 16'hBEEF;
        do begin @(negedge clk); n++; end while (!d_done && n < 20);
        total++;
        if (!d_done) $display("FAIL dwr_timeout: d_done=%b want 1", d_done); else passed++;
        d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1;
        total++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 16'h1000 || wr_data[0] !== 16'hBEEF)
            $display("FAIL dwr_access: n %0d addr %h data %h want 1 1000 beef", wr_addr.size(), wr_addr[0], wr_data[0]);
        else passed++;
        total++;
        if (d_done_cyc != wr_cyc[0] + 1) $display("FAIL dwr_done_cycle: got %0d want %0d", d_done_cyc, wr_cyc[0] + 1);
        else passed++;
        total++;
        if (rd_addr.size() != 0 || fw.size() != 0 || d_done_cnt != 1 || i_done_cnt != 0)
            $display("FAIL dwr_side: reads %0d fills %0d ddone %0d idone %0d want 0 0 1 0", rd_addr.size(), fw.size(), d_done_cnt, i_done_cnt);
        else passed++;
    endtask

    task automatic test_contention;
        bit          order [2];
        bit          first_d;
        logic [15:0] base;
        int          n = 0;
`ifdef ROUND_ROBIN_EN
        first_d = 1'b0;   // D was granted last (store), so I goes first
`else
        first_d = 1'b1;
`endif
        clear_logs();
        i_req = 1'b1; i_addr = 16'h0104;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h2004;
        for (int t = 0; t < 2; t++) begin
            do begin @(negedge clk); n++; end while (!i_done && !d_done && n < 200);
            order[t] = d_done;
            if (d_done) d_req = 1'b0;
            if (i_done) i_req = 1'b0;
        end
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        total++;
        if (order[0] !== first_d || order[1] !== !first_d)
            $display("FAIL contention_order: got %b%b want %b%b", order[0], order[1], first_d, !first_d);
        else passed++;
        total++;
        if (rd_addr.size() != 2 * W || fw.size() != 2 * W || both_err != 0)
            $display("FAIL contention_counts: reads %0d fills %0d excl %0d want %0d %0d 0", rd_addr.size(), fw.size(), both_err, 2 * W, 2 * W);
        else passed++;
        for (int k = 0; k < 2 * W; k++) begin
            logic       side;
            logic [15:0] ea;
            side = (k < W) ? first_d : !first_d;
            base = side ? 16'h2000 : 16'h0100;
            ea   = base + 16'(2 * (k % W));
            total++;
            if (rd_addr[k] !== ea || fw[k] !== 3'(k % W) || fd[k] !== (ea ^ 16'hA5A5) || fside[k] !== side)
                $display("FAIL contention_word%0d: addr %h word %0d data %h side %b want %h %0d %h %b", k, rd_addr[k], fw[k], fd[k], fside[k], ea, k % W, ea ^ 16'hA5A5, side);
            else passed++;
        end
    endtask

    task automatic test_arbitration_rounds;
        bit exp_d [2];
`ifdef ROUND_ROBIN_EN
        exp_d[0] = 1'b0; exp_d[1] = 1'b1;   // last grant was D: alternate I then D
`else
        exp_d[0] = 1'b1; exp_d[1] = 1'b1;
`endif
        for (int rnd = 0; rnd < 2; rnd++) begin
            int n = 0;
            bit got_d;
            clear_logs();
            i_req = 1'b1; i_addr = 16'h0200;
            d_req = 1'b1; d_we = 1'b1; d_addr = 16'h1234; d_wdata = 16'h5678;
            do begin @(negedge clk); n++; end while (!i_done && !d_done && n < 100);
            got_d = d_done;
            i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            total++;
            if (got_d !== exp_d[rnd] || (i_done_cnt + d_done_cnt) != 1 || busy !== 1'b0)
                $display("FAIL round%0d_grant: d_granted %b dones %0d busy %b want %b 1 0", rnd, got_d, i_done_cnt + d_done_cnt, busy, exp_d[rnd]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_fill;
        int nf = 0;
        int n  = 0;
        clear_logs();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h3006;
        do begin @(negedge clk); n++; if (d_fill_we) nf++; end while (nf < 3 && n < 100);
        total++;
        if (nf != 3) $display("FAIL rstmid_returns: got %0d want 3", nf); else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word, i_fill_we, d_fill_we, i_done, d_done, busy} !== 58'd0)
            $display("FAIL rstmid_outputs: got %h want 0", {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word, i_fill_we, d_fill_we, i_done, d_done, busy});
        else passed++;
        d_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (fw.size() != 0 || valid_cnt == 0 || busy !== 1'b0 || d_done_cnt != 0)
            $display("FAIL rstmid_late_returns: fills %0d valids %0d busy %b ddone %0d want 0 >0 0 0", fw.size(), valid_cnt, busy, d_done_cnt);
        else passed++;
    endtask

    task automatic test_req_drop;
        int nr = 0;
        int n  = 0;
        clear_logs();
        i_req = 1'b1; i_addr = 16'h0456;
        do begin @(negedge clk); n++; if (mem_en) nr++; end while (nr < 2 && n < 50);
        i_req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!i_done && n < 100);
        total++;
        if (!i_done) $display("FAIL drop_timeout: i_done=%b want 1", i_done); else passed++;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) $display("FAIL drop_busy: got %b want 0", busy); else passed++;
        total++;
        if (rd_addr.size() != W || fw.size() != W || i_done_cnt != 1 || d_done_cnt != 0)
            $display("FAIL drop_counts: reads %0d fills %0d idone %0d ddone %0d want %0d %0d 1 0", rd_addr.size(), fw.size(), i_done_cnt, d_done_cnt, W, W);
        else passed++;
        for (int k = 0; k < W; k++) begin
            logic [15:0] ea;
            ea = 16'h0450 + 16'(2 * k);
            total++;
            if (rd_addr[k] !== ea || fw[k] !== 3'(k) || fd[k] !== (ea ^ 16'hA5A5) || fside[k] !== 1'b0)
                $display("FAIL drop_word%0d: addr %h word %0d data %h side %b want %h %0d %h 0", k, rd_addr[k], fw[k], fd[k], fside[k], ea, k, ea ^ 16'hA5A5);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_i_fill();
        test_d_write();
        test_contention();
        test_arbitration_rounds();
        test_reset_mid_fill();
        test_req_drop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, total);
        $fatal(1);
    end

endmodule
